// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, FSM encoding and request type for the register-file write arbiter.
// Register 0 is hardwired and is never a legal write target.
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam int AUX_DEPTH  = 2;
  localparam int AUX_CNT_W  = $clog2(AUX_DEPTH + 1);

  localparam logic [REG_ADDR_W-1:0] FIRST_CLR_REG = REG_ADDR_W'(1);
  localparam logic [REG_ADDR_W-1:0] LAST_REG      = REG_ADDR_W'(NUM_REGS - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     dat;
  } wr_req_t;

  function automatic logic is_writable(input logic [REG_ADDR_W-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/regwr_fifo.sv
// Small generic FIFO: 0-cycle head visibility of registered entries, push ignored when full,
// pop ignored when empty; a push is never visible at the head in the same cycle.
module regwr_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic                       core_clk,
  input  logic                       arst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [W-1:0]               head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: zeroes regs 1..31 after reset, then grants WB over a 2-deep aux FIFO.
// Outputs registered (1 edge for WB, >=2 edges for aux); aux backpressured via auxReady from registered count.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
(
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  wbValid,
  input  logic [REG_ADDR_W-1:0] wbReg,
  input  logic [DATA_W-1:0]     wbData,
  input  logic                  auxValid,
  output logic                  auxReady,
  input  logic [REG_ADDR_W-1:0] auxReg,
  input  logic [DATA_W-1:0]     auxData,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0]     writeData,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic [REG_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0]     write_data_q, write_data_d;

  wr_req_t               aux_req;
  wr_req_t               fifo_head;
  logic [AUX_CNT_W-1:0]  fifo_count;
  logic                  fifo_push, fifo_pop;
  logic                  aux_ready;
  logic                  wb_sel;

  assign aux_req   = {auxReg, auxData};
  // Readiness uses the registered count only, so a full FIFO never accepts even if it pops this cycle.
  assign aux_ready = (state_q == ST_RUN) && (fifo_count < AUX_CNT_W'(AUX_DEPTH));
  assign fifo_push = auxValid && aux_ready;
  assign wb_sel    = wbValid && is_writable(wbReg);

  regwr_fifo #(
    .W     ($bits(wr_req_t)),
    .DEPTH (AUX_DEPTH)
  ) u_fifo (
    .core_clk (clock_in),
    .arst_n   (reset),
    .push     (fifo_push),
    .push_dat (aux_req),
    .pop      (fifo_pop),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        reg_write_d  = 1'b1;
        write_reg_d  = clr_cnt_q;
        write_data_d = '0;
        if (clr_cnt_q == LAST_REG) begin
          state_d   = ST_RUN;
          clr_cnt_d = FIRST_CLR_REG;
        end else begin
          clr_cnt_d = clr_cnt_q + REG_ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (wb_sel) begin
          reg_write_d  = 1'b1;
          write_reg_d  = wbReg;
          write_data_d = wbData;
        end else if (fifo_count != '0) begin
          // A queued write to r0 is consumed silently so it cannot stall the queue.
          fifo_pop = 1'b1;
          if (is_writable(fifo_head.reg_addr)) begin
            reg_write_d  = 1'b1;
            write_reg_d  = fifo_head.reg_addr;
            write_data_d = fifo_head.dat;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= FIRST_CLR_REG;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign auxReady  = aux_ready;
  assign regWrite  = reg_write_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;
  assign busy      = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: hand vectors, reset/clear sequences and random traffic vs a queue model.
module tb_regfile_write_arbiter;

  logic        clock_in = 1'b0;
  logic        reset    = 1'b1;
  logic        wbValid  = 1'b0;
  logic [4:0]  wbReg    = '0;
  logic [31:0] wbData   = '0;
  logic        auxValid = 1'b0;
  logic [4:0]  auxReg   = '0;
  logic [31:0] auxData  = '0;
  logic        auxReady;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        busy;

  always #5 clock_in = ~clock_in;

  regfile_write_arbiter dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .wbValid   (wbValid),
    .wbReg     (wbReg),
    .wbData    (wbData),
    .auxValid  (auxValid),
    .auxReady  (auxReady),
    .auxReg    (auxReg),
    .auxData   (auxData),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .busy      (busy)
  );

  int checks = 0;
  int errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: clear phase as a register walk, aux buffer as a bounded queue.
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } req_t;

  req_t        mq[$];
  bit          m_clear;
  int          m_cnt;
  logic        m_rw;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  task automatic model_reset();
    m_clear = 1'b1;
    m_cnt   = 1;
    mq.delete();
    m_rw    = 1'b0;
    m_reg   = '0;
    m_data  = '0;
  endtask

  task automatic model_edge();
    bit   accept;
    req_t h;
    if (m_clear) begin
      m_rw   = 1'b1;
      m_reg  = 5'(m_cnt);
      m_data = '0;
      if (m_cnt == 31) m_clear = 1'b0;
      else m_cnt++;
    end else begin
      accept = auxValid && (mq.size() < 2);
      if (wbValid && wbReg != 5'd0) begin
        m_rw   = 1'b1;
        m_reg  = wbReg;
        m_data = wbData;
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        if (h.r != 5'd0) begin
          m_rw   = 1'b1;
          m_reg  = h.r;
          m_data = h.d;
        end else begin
          m_rw = 1'b0;
        end
      end else begin
        m_rw = 1'b0;
      end
      if (accept) begin
        h.r = auxReg;
        h.d = auxData;
        mq.push_back(h);
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".regWrite"},  32'(regWrite),  32'(m_rw));
    check({tag, ".writeReg"},  32'(writeReg),  32'(m_reg));
    check({tag, ".writeData"}, writeData,      m_data);
    check({tag, ".busy"},      32'(busy),      32'(m_clear));
    check({tag, ".auxReady"},  32'(auxReady),  32'(!m_clear && mq.size() < 2));
  endtask

  task automatic step(input string tag);
    @(posedge clock_in);
    if (reset) model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic av, input logic [4:0] ar, input logic [31:0] ad);
    wbValid  = wv;
    wbReg    = wr;
    wbData   = wd;
    auxValid = av;
    auxReg   = ar;
    auxData  = ad;
  endtask

  task automatic pulse_reset(input int cycles);
    reset = 1'b0;
    model_reset();
    #1;
    compare_all("rst");
    repeat (cycles) step("rst_hold");
    reset = 1'b1;
  endtask

  // Walks the 31 clear writes while presenting requests that must be ignored.
  task automatic clear_seq(input string tag);
    for (int k = 1; k <= 31; k++) begin
      drive(1'b1, 5'd5, 32'hBAD0_0000 + 32'(k), 1'b1, 5'd6, 32'hBAD1_0000 + 32'(k));
      step(tag);
      check({tag, ".clr_we"},   32'(regWrite), 32'd1);
      check({tag, ".clr_reg"},  32'(writeReg), 32'(k));
      check({tag, ".clr_data"}, writeData,     32'd0);
      check({tag, ".clr_busy"}, 32'(busy),     32'(k < 31));
      check({tag, ".clr_rdy"},  32'(auxReady), 32'(k == 31));
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  typedef struct {
    logic        wv;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        rw;
    logic [4:0]  rg;
    logic [31:0] dt;
    logic        rdy;
  } vec_t;

  vec_t vt[16];

  initial begin
    vt[0]  = '{1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0,  32'h0,   1'b1, 5'd5, 32'h12345678, 1'b1};
    vt[1]  = '{1'b1, 5'd7, 32'h77,       1'b1, 5'd3,  32'hA,   1'b1, 5'd7, 32'h77,       1'b1};
    vt[2]  = '{1'b1, 5'd7, 32'h78,       1'b1, 5'd4,  32'hB,   1'b1, 5'd7, 32'h78,       1'b0};
    vt[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd10, 32'hD,   1'b1, 5'd3, 32'hA,        1'b1};
    vt[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd4, 32'hB,        1'b1};
    vt[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,   1'b0, 5'd4, 32'hB,        1'b1};
    vt[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9,  32'hC,   1'b0, 5'd4, 32'hB,        1'b1};
    vt[7]  = '{1'b1, 5'd0, 32'hDEAD,     1'b0, 5'd0,  32'h0,   1'b1, 5'd9, 32'hC,        1'b1};
    vt[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0,  32'h55,  1'b0, 5'd9, 32'hC,        1'b1};
    vt[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,   1'b0, 5'd9, 32'hC,        1'b1};
    vt[10] = '{1'b1, 5'd2, 32'h22,       1'b1, 5'd6,  32'h66,  1'b1, 5'd2, 32'h22,       1'b1};
    vt[11] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd8,  32'h88,  1'b1, 5'd6, 32'h66,       1'b1};
    vt[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd8, 32'h88,       1'b1};
    vt[13] = '{1'b1, 5'd6, 32'h600,      1'b1, 5'd6,  32'h601, 1'b1, 5'd6, 32'h600,      1'b1};
    vt[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,   1'b1, 5'd6, 32'h601,      1'b1};
    vt[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0,  32'h0,   1'b0, 5'd6, 32'h601,      1'b1};

    #2;
    pulse_reset(3);
    check("reset.busy", 32'(busy), 32'd1);
    clear_seq("clear1");
    step("idle_after_clear");
    check("idle_after_clear.we", 32'(regWrite), 32'd0);

    for (int i = 0; i < 16; i++) begin
      drive(vt[i].wv, vt[i].wr, vt[i].wd, vt[i].av, vt[i].ar, vt[i].ad);
      step($sformatf("vec%0d", i));
      check($sformatf("vec%0d.we", i),   32'(regWrite), 32'(vt[i].rw));
      check($sformatf("vec%0d.reg", i),  32'(writeReg), 32'(vt[i].rg));
      check($sformatf("vec%0d.data", i), writeData,     vt[i].dt);
      check($sformatf("vec%0d.rdy", i),  32'(auxReady), 32'(vt[i].rdy));
    end

    // Fill the queue behind WB traffic, then reset: queued writes must vanish.
    drive(1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'h1);
    step("fill0");
    drive(1'b1, 5'd11, 32'h12, 1'b1, 5'd13, 32'h2);
    step("fill1");
    check("queued_full.rdy", 32'(auxReady), 32'd0);
    drive(1'b1, 5'd11, 32'h13, 1'b1, 5'd14, 32'h3);
    pulse_reset(2);
    check("rst_run.we",   32'(regWrite),  32'd0);
    check("rst_run.reg",  32'(writeReg),  32'd0);
    check("rst_run.data", writeData,      32'd0);
    clear_seq("clear2");
    for (int i = 0; i < 3; i++) begin
      step("drained");
      check("drained.we", 32'(regWrite), 32'd0);
    end

    // Reset in the middle of the clear walk restarts from register 1.
    pulse_reset(1);
    for (int i = 0; i < 6; i++) step("partial_clear");
    check("partial_clear.reg", 32'(writeReg), 32'd6);
    pulse_reset(1);
    clear_seq("clear3");

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset(1);
      end else begin
        drive(1'($urandom_range(0, 99) < 40), 5'($urandom_range(0, 6)), $urandom,
              1'($urandom_range(0, 99) < 55), 5'($urandom_range(0, 6)), $urandom);
        step("rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have port: clock_in  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port: wbValid  input  1  pipeline writeback write request; no backpressure.
REQ-004 SHALL have port: wbReg  input  5  writeback destination register.
REQ-005 SHALL have port: wbData  input  32  writeback data.
REQ-006 SHALL have port: auxValid  input  1  auxiliary (multi-cycle unit) write request.
REQ-007 SHALL have port: auxReady  output  1  aux request accepted when auxValid and auxReady are both 1 at a rising edge.
REQ-008 SHALL have port: auxReg  input  5  aux destination register.
REQ-009 SHALL have port: auxData  input  32  aux data.
REQ-010 SHALL have port: regWrite  output  1  register-file write enable.
REQ-011 SHALL have port: writeReg  output  5  register-file write address.
REQ-012 SHALL have port: writeData  output  32  register-file write data.
REQ-013 SHALL have port: busy  output  1  high while the clear sequence runs; pipeline must not issue.

Function
REQ-014 SHALL implement states CLEAR and RUN; CLEAR entered on reset.
REQ-015 In CLEAR, SHALL drive regWrite=1, writeData=0, writeReg=clear counter, counter stepping 1..31, one register per cycle.
REQ-016 After the cycle writing register 31, SHALL enter RUN and deassert busy in the same edge; CLEAR lasts exactly 31 write cycles.
REQ-017 In CLEAR, SHALL ignore wbValid and hold auxReady=0.
REQ-018 SHALL buffer aux requests in a 2-entry FIFO; auxReady = RUN and FIFO count < 2, computed from registered count (no same-cycle push-through when full).
REQ-019 Each RUN cycle, SHALL select: wbValid with wbReg != 0 -> write WB; else FIFO non-empty -> pop head and write it; else regWrite=0.
REQ-020 WB requests with wbReg == 0 SHALL produce no write and SHALL NOT block FIFO service that cycle.
REQ-021 FIFO head with reg 0 SHALL be popped with no write (regWrite=0).
REQ-022 regWrite/writeReg/writeData SHALL be registered: selection at edge N appears on outputs after edge N and holds for one cycle.
REQ-023 A request pushed at edge N SHALL be eligible for pop at edge N+1 at the earliest (aux latency >= 2 edges to output).
REQ-024 Simultaneous push and pop with count 1 SHALL leave count 1 with correct order; FIFO order strictly first-in first-out.
REQ-025 Same-destination WB and aux writes SHALL NOT be merged or reordered; aux is applied after any WB granted in the same cycle.
REQ-026 When regWrite=0, writeReg and writeData SHALL hold previous values.

Reset
REQ-027 While reset=0: state=CLEAR, counter=1, FIFO empty, regWrite=0, writeReg=0, writeData=0, auxReady=0, busy=1.
REQ-028 Reset asserted mid-CLEAR SHALL restart the sequence at register 1; mid-RUN SHALL discard FIFO contents.
REQ-029 First CLEAR write SHALL appear on the first rising edge after reset deassertion.

Structure
REQ-030 Shared package/header SHALL hold REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, AUX_DEPTH=2, and the CLEAR/RUN state encoding.
REQ-031 The 2-entry FIFO SHALL be a sub-module named regwr_fifo (push, pop, count, head outputs); all else in the top module.

Verification
REQ-032 Release reset -> 31 consecutive writes regs 1..31 with data 0, busy falls after reg 31, register 0 never written.
REQ-033 RUN, wbValid=1 wbReg=5 wbData=0x12345678 -> next cycle regWrite=1 writeReg=5 writeData=0x12345678.
REQ-034 RUN, aux pushes (3,0xA),(4,0xB) while wbValid=1 reg 7 for 2 cycles -> auxReady=0 after 2nd push, writes 7,7,3,4 in order.
REQ-035 RUN, wbValid=1 wbReg=0 with FIFO head (9,0xC) -> write reg 9 data 0xC that cycle; reg 0 never written.
REQ-036 Reset pulsed with 2 aux entries queued -> FIFO empty, full CLEAR sequence repeats, queued writes never appear.
